// File: rtl/ddram_pkg.sv
// Shared state encoding, default ROM region base and lane helpers for ddram_port.
package ddram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_CMD  = 2'd1,
    ST_RD_CMD  = 2'd2,
    ST_RD_WAIT = 2'd3
  } ddram_state_t;

  localparam logic [6:0] DDRAM_BASE_DEF = 7'b0011000;

  function automatic logic [15:0] lane_sel(input logic [63:0] word, input logic [1:0] idx);
    logic [15:0] lane;
    case (idx)
      2'd0:    lane = word[15:0];
      2'd1:    lane = word[31:16];
      2'd2:    lane = word[47:32];
      2'd3:    lane = word[63:48];
      default: lane = 16'h0000;
    endcase
    return lane;
  endfunction

  function automatic logic [7:0] lane_be(input logic [1:0] idx);
    return 8'b0000_0011 << {idx, 1'b0};
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchronizer for a request toggle; both flops clear on reset.
module toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage resynchronisation of the incoming toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/ddram_port.sv
// Toggle-handshake bridge from the ROM write/read channels to the DDRAM Avalon master.
// Optional one-line read cache enabled by defining DDRAM_RDCACHE_EN.
module ddram_port
  import ddram_pkg::*;
#(
  parameter logic [6:0] BASE = DDRAM_BASE_DEF
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  input  logic [24:0] wraddr,
  input  logic [15:0] din,
  input  logic        we_req,
  output logic        we_ack,
  input  logic [23:0] rdaddr,
  output logic [15:0] dout,
  input  logic        rd_req,
  output logic        rd_ack,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  ddram_state_t state_r, state_s;
  logic        we_sync_s, rd_sync_s, we_pend_s, rd_pend_s;
  logic        hit_s;
  logic [15:0] hit_data_s;
  logic        we_ack_r, we_ack_s, rd_ack_r, rd_ack_s;
  logic        we_r, we_s, rd_r, rd_s;
  logic [15:0] dout_r, dout_s;
  logic [28:0] addr_r, addr_s;
  logic [63:0] din_r, din_s;
  logic [7:0]  be_r, be_s;
  logic [1:0]  lane_r, lane_s;
  logic        unused_s;

  toggle_sync u_we_sync (.clk(DDRAM_CLK), .rst(reset), .d(we_req), .q(we_sync_s));
  toggle_sync u_rd_sync (.clk(DDRAM_CLK), .rst(reset), .d(rd_req), .q(rd_sync_s));

  assign we_pend_s = we_sync_s ^ we_ack_r;
  assign rd_pend_s = rd_sync_s ^ rd_ack_r;
  assign unused_s  = wraddr[0];

`ifdef DDRAM_RDCACHE_EN
  logic [63:0] line_r, merge_s;
  logic [21:0] ctag_r;
  logic        cvalid_r, wr_seen_r;

  assign hit_s      = cvalid_r & (ctag_r == rdaddr[23:2]);
  assign hit_data_s = lane_sel(line_r, rdaddr[1:0]);

  // Byte-merge of the write being accepted into the cached line
  always_comb begin
    merge_s = line_r;
    for (int b = 0; b < 8; b++) begin
      if (be_r[b]) merge_s[8*b +: 8] = din_r[8*b +: 8];
      else         merge_s[8*b +: 8] = line_r[8*b +: 8];
    end
  end

  // Line fill on read miss; first write after reset invalidates, later writes patch
  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      line_r    <= 64'h0;
      ctag_r    <= 22'h0;
      cvalid_r  <= 1'b0;
      wr_seen_r <= 1'b0;
    end else if (state_r == ST_RD_WAIT && DDRAM_DOUT_READY) begin
      line_r   <= DDRAM_DOUT;
      ctag_r   <= addr_r[21:0];
      cvalid_r <= 1'b1;
    end else if (state_r == ST_WR_CMD && !DDRAM_BUSY) begin
      wr_seen_r <= 1'b1;
      if (!wr_seen_r) begin
        cvalid_r <= 1'b0;
      end else if (cvalid_r && ctag_r == addr_r[21:0]) begin
        line_r <= merge_s;
      end
    end
  end
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = 16'h0000;
`endif

  // Next-state and next-output decode; every output is registered below
  always_comb begin
    state_s  = state_r;
    we_ack_s = we_ack_r;
    rd_ack_s = rd_ack_r;
    we_s     = we_r;
    rd_s     = rd_r;
    dout_s   = dout_r;
    addr_s   = addr_r;
    din_s    = din_r;
    be_s     = be_r;
    lane_s   = lane_r;
    case (state_r)
      ST_IDLE: begin
        if (we_pend_s) begin
          state_s = ST_WR_CMD;
          we_s    = 1'b1;
          addr_s  = {BASE, wraddr[24:3]};
          din_s   = {4{din}};
          be_s    = lane_be(wraddr[2:1]);
          lane_s  = wraddr[2:1];
        end else if (rd_pend_s) begin
          if (hit_s) begin
            dout_s   = hit_data_s;
            rd_ack_s = ~rd_ack_r;
          end else begin
            state_s = ST_RD_CMD;
            rd_s    = 1'b1;
            addr_s  = {BASE, rdaddr[23:2]};
            lane_s  = rdaddr[1:0];
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_CMD: begin
        if (!DDRAM_BUSY) begin
          we_s     = 1'b0;
          we_ack_s = ~we_ack_r;
          state_s  = ST_IDLE;
        end else begin
          we_s = 1'b1;
        end
      end
      ST_RD_CMD: begin
        if (!DDRAM_BUSY) begin
          rd_s    = 1'b0;
          state_s = ST_RD_WAIT;
        end else begin
          rd_s = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (DDRAM_DOUT_READY) begin
          dout_s   = lane_sel(DDRAM_DOUT, lane_r);
          rd_ack_s = ~rd_ack_r;
          state_s  = ST_IDLE;
        end else begin
          state_s = ST_RD_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        we_s    = 1'b0;
        rd_s    = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      we_ack_r <= 1'b0;
      rd_ack_r <= 1'b0;
      we_r     <= 1'b0;
      rd_r     <= 1'b0;
      dout_r   <= 16'h0000;
      addr_r   <= 29'h0;
      din_r    <= 64'h0;
      be_r     <= 8'h00;
      lane_r   <= 2'd0;
    end else begin
      state_r  <= state_s;
      we_ack_r <= we_ack_s;
      rd_ack_r <= rd_ack_s;
      we_r     <= we_s;
      rd_r     <= rd_s;
      dout_r   <= dout_s;
      addr_r   <= addr_s;
      din_r    <= din_s;
      be_r     <= be_s;
      lane_r   <= lane_s;
    end
  end

  assign we_ack         = we_ack_r;
  assign rd_ack         = rd_ack_r;
  assign dout           = dout_r;
  assign DDRAM_WE       = we_r;
  assign DDRAM_RD       = rd_r;
  assign DDRAM_ADDR     = addr_r;
  assign DDRAM_DIN      = din_r;
  assign DDRAM_BE       = be_r;
  assign DDRAM_BURSTCNT = 8'd1;

endmodule

// File: tb/tb_ddram_port.sv
// Directed plus randomized bench for ddram_port against a memory-level reference model.
module tb_ddram_port;

  localparam logic [6:0] EXP_BASE = 7'b0011000;

  logic        DDRAM_CLK = 1'b0;
  logic        reset;
  logic [24:0] wraddr;
  logic [15:0] din;
  logic        we_req;
  logic        we_ack;
  logic [23:0] rdaddr;
  logic [15:0] dout;
  logic        rd_req;
  logic        rd_ack;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  always #5 DDRAM_CLK = ~DDRAM_CLK;

  ddram_port dut (
    .DDRAM_CLK(DDRAM_CLK), .reset(reset), .wraddr(wraddr), .din(din), .we_req(we_req),
    .we_ack(we_ack), .rdaddr(rdaddr), .dout(dout), .rd_req(rd_req), .rd_ack(rd_ack),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD),
    .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
  );

  int checks = 0;
  int errors = 0;
  int rd_hi = 0, we_hi = 0, both_hi = 0, bad_burst = 0;

  // Reference model: DDR contents by word address, plus the cache's architectural state
  logic [63:0] mem [logic [21:0]];
  bit          c_valid = 1'b0;
  bit          c_wr_seen = 1'b0;
  logic [21:0] c_tag = 22'h0;

  // Command-cycle counters sampled on each rising edge
  always @(posedge DDRAM_CLK) begin
    if (DDRAM_RD) rd_hi <= rd_hi + 1;
    if (DDRAM_WE) we_hi <= we_hi + 1;
    if (DDRAM_RD && DDRAM_WE) both_hi <= both_hi + 1;
    if (DDRAM_BURSTCNT !== 8'd1) bad_burst <= bad_burst + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lane_of(input logic [63:0] w, input logic [1:0] l);
    return 16'(w >> (16 * l));
  endfunction

  function automatic logic [7:0] be_of(input logic [1:0] l);
    return 8'((8'h1 << (2 * l)) | (8'h1 << (2 * l + 1)));
  endfunction

  task automatic get_word(input logic [21:0] w, output logic [63:0] v);
    if (!mem.exists(w)) mem[w] = {$urandom, $urandom};
    v = mem[w];
  endtask

  task automatic model_write(input logic [24:0] a, input logic [15:0] d);
    logic [63:0] v;
    get_word(a[24:3], v);
    v = (v & ~(64'hFFFF << (16 * a[2:1]))) | ({48'h0, d} << (16 * a[2:1]));
    mem[a[24:3]] = v;
    if (!c_wr_seen) c_valid = 1'b0;
    c_wr_seen = 1'b1;
  endtask

  task automatic wait_for(input bit want_we, output int idx);
    idx = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge DDRAM_CLK);
      if (want_we ? DDRAM_WE : DDRAM_RD) begin
        idx = i;
        break;
      end
    end
  endtask

  task automatic wr_finish(input logic [24:0] a, input logic [15:0] d, input int busy_n, input logic ack0);
    logic [28:0] ea;
    logic [63:0] ed;
    logic [7:0]  eb;
    ea = {EXP_BASE, a[24:3]};
    ed = {d, d, d, d};
    eb = be_of(a[2:1]);
    chk("wr_addr", DDRAM_ADDR, ea);
    chk("wr_din", DDRAM_DIN, ed);
    chk("wr_be", DDRAM_BE, eb);
    chk("wr_no_rd", DDRAM_RD, 1'b0);
    chk("wr_ack_hold", we_ack, ack0);
    DDRAM_BUSY = (busy_n > 0);
    for (int k = 0; k < busy_n; k++) begin
      @(negedge DDRAM_CLK);
      chk("wr_busy_we", DDRAM_WE, 1'b1);
      chk("wr_busy_addr", DDRAM_ADDR, ea);
      chk("wr_busy_din", DDRAM_DIN, ed);
      chk("wr_busy_be", DDRAM_BE, eb);
      chk("wr_busy_ack", we_ack, ack0);
      if (k == busy_n - 1) DDRAM_BUSY = 1'b0;
    end
    @(negedge DDRAM_CLK);
    chk("we_drop", DDRAM_WE, 1'b0);
    chk("we_ack", we_ack, !ack0);
  endtask

  task automatic do_write(input logic [24:0] a, input logic [15:0] d, input int busy_n);
    logic ack0;
    int   we0, idx;
    ack0 = we_ack;
    we0 = we_hi;
    wraddr = a;
    din = d;
    we_req = ~we_req;
    wait_for(1'b1, idx);
    chk("wr_lat", idx, 3);
    if (idx != 0) wr_finish(a, d, busy_n, ack0);
    chk("we_cycles", we_hi - we0, busy_n + 1);
    model_write(a, d);
  endtask

  task automatic rd_finish(input logic [23:0] a, input int busy_n, input int lat, input logic ack0, input logic [63:0] w);
    logic [28:0] ea;
    ea = {EXP_BASE, a[23:2]};
    chk("rd_addr", DDRAM_ADDR, ea);
    chk("rd_no_we", DDRAM_WE, 1'b0);
    DDRAM_BUSY = (busy_n > 0);
    for (int k = 0; k < busy_n; k++) begin
      @(negedge DDRAM_CLK);
      chk("rd_busy_rd", DDRAM_RD, 1'b1);
      chk("rd_busy_addr", DDRAM_ADDR, ea);
      if (k == busy_n - 1) DDRAM_BUSY = 1'b0;
    end
    @(negedge DDRAM_CLK);
    chk("rd_drop", DDRAM_RD, 1'b0);
    for (int k = 1; k < lat; k++) begin
      DDRAM_DOUT = {$urandom, $urandom};
      @(negedge DDRAM_CLK);
    end
    chk("rd_ack_wait", rd_ack, ack0);
    DDRAM_DOUT = w;
    DDRAM_DOUT_READY = 1'b1;
    @(negedge DDRAM_CLK);
    DDRAM_DOUT_READY = 1'b0;
    DDRAM_DOUT = {$urandom, $urandom};
    chk("rd_ack", rd_ack, !ack0);
    chk("rd_dout", dout, lane_of(w, a[1:0]));
  endtask

  task automatic do_read(input logic [23:0] a, input int busy_n, input int lat);
    logic        ack0;
    logic [63:0] w;
    int          rd0, idx;
    bit          hit;
    ack0 = rd_ack;
    rd0 = rd_hi;
    hit = 1'b0;
`ifdef DDRAM_RDCACHE_EN
    hit = c_valid && (c_tag == a[23:2]);
`endif
    get_word(a[23:2], w);
    rdaddr = a;
    rd_req = ~rd_req;
    if (hit) begin
      repeat (3) @(negedge DDRAM_CLK);
      chk("hit_ack", rd_ack, !ack0);
      chk("hit_dout", dout, lane_of(w, a[1:0]));
      chk("hit_no_rd", rd_hi - rd0, 0);
    end else begin
      wait_for(1'b0, idx);
      chk("rd_lat", idx, 3);
      if (idx != 0) rd_finish(a, busy_n, lat, ack0, w);
      chk("rd_cycles", rd_hi - rd0, busy_n + 1);
      c_valid = 1'b1;
      c_tag = a[23:2];
    end
  endtask

  initial begin
    logic [63:0] w;
    logic        ackw, ackr;
    int          idx, rd0;
    logic [21:0] word;
    logic [1:0]  ln;

    reset = 1'b1;
    wraddr = 25'h0; din = 16'h0; we_req = 1'b0; rdaddr = 24'h0; rd_req = 1'b0;
    DDRAM_BUSY = 1'b0; DDRAM_DOUT = 64'h0; DDRAM_DOUT_READY = 1'b0;
    repeat (3) @(negedge DDRAM_CLK);
    chk("rst_we", DDRAM_WE, 1'b0);
    chk("rst_rd", DDRAM_RD, 1'b0);
    chk("rst_addr", DDRAM_ADDR, 29'h0);
    chk("rst_din", DDRAM_DIN, 64'h0);
    chk("rst_be", DDRAM_BE, 8'h0);
    chk("rst_burst", DDRAM_BURSTCNT, 8'd1);
    reset = 1'b0;
    repeat (4) @(negedge DDRAM_CLK);
    chk("idle_we_ack", we_ack, 1'b0);
    chk("idle_rd_ack", rd_ack, 1'b0);
    chk("idle_dout", dout, 16'h0);
    chk("idle_no_cmd", rd_hi + we_hi, 0);

    // Single write, then the same write held off by BUSY for 5 cycles
    do_write(25'h000182, 16'hABCD, 0);
    do_write(25'h000182, 16'hABCD, 5);

    // Read miss with data 7 cycles later, then a neighbouring lane of the same word
    mem[22'h0] = 64'h4444_3333_2222_1111;
    do_read(24'h000003, 0, 7);
    do_read(24'h000002, 0, 3);
    do_write(25'h000004, 16'h5555, 0);
    do_read(24'h000002, 1, 2);

    // Stray read data while idle must be ignored
    ackr = rd_ack;
    w = {48'h0, dout};
    DDRAM_DOUT = {$urandom, $urandom};
    DDRAM_DOUT_READY = 1'b1;
    @(negedge DDRAM_CLK);
    DDRAM_DOUT_READY = 1'b0;
    repeat (2) @(negedge DDRAM_CLK);
    chk("stray_ack", rd_ack, ackr);
    chk("stray_dout", dout, w[15:0]);

    // Simultaneous requests: write first, read after the write ack
    ackw = we_ack;
    ackr = rd_ack;
    get_word(22'h5, w);
    wraddr = 25'({22'h10, 2'd1, 1'b0});
    din = 16'h1234;
    rdaddr = {22'h5, 2'd2};
    we_req = ~we_req;
    rd_req = ~rd_req;
    wait_for(1'b1, idx);
    chk("sim_wr_lat", idx, 3);
    chk("sim_rd_held_off", DDRAM_RD, 1'b0);
    if (idx != 0) wr_finish(25'({22'h10, 2'd1, 1'b0}), 16'h1234, 0, ackw);
    model_write(25'({22'h10, 2'd1, 1'b0}), 16'h1234);
    chk("sim_rd_not_yet", DDRAM_RD, 1'b0);
    @(negedge DDRAM_CLK);
    chk("sim_rd_issue", DDRAM_RD, 1'b1);
    if (DDRAM_RD) rd_finish({22'h5, 2'd2}, 0, 2, ackr, w);
    chk("sim_we_ack_once", we_ack, !ackw);
    c_valid = 1'b1;
    c_tag = 22'h5;

    // Randomized mix over a few words so cache hits and merges occur
    for (int n = 0; n < 30; n++) begin
      word = 22'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) word[21:20] = 2'($urandom);
      ln = 2'($urandom);
      if ($urandom_range(0, 2) == 0)
        do_write({word, ln, 1'($urandom)}, 16'($urandom), $urandom_range(0, 3));
      else
        do_read({word, ln}, $urandom_range(0, 3), $urandom_range(1, 5));
    end

    // Reset while waiting for read data: outputs clear at once, late data ignored
    get_word(22'h7, w);
    rdaddr = {22'h7, 2'd1};
    rd_req = ~rd_req;
    wait_for(1'b0, idx);
    chk("rst_rd_lat", idx, 3);
    @(negedge DDRAM_CLK);
    reset = 1'b1;
    rd_req = 1'b0;
    we_req = 1'b0;
    #1;
    chk("arst_we_ack", we_ack, 1'b0);
    chk("arst_rd_ack", rd_ack, 1'b0);
    chk("arst_dout", dout, 16'h0);
    chk("arst_rd", DDRAM_RD, 1'b0);
    chk("arst_we", DDRAM_WE, 1'b0);
    chk("arst_addr", DDRAM_ADDR, 29'h0);
    chk("arst_din", DDRAM_DIN, 64'h0);
    chk("arst_be", DDRAM_BE, 8'h0);
    c_valid = 1'b0;
    c_wr_seen = 1'b0;
    rd0 = rd_hi;
    DDRAM_DOUT = w;
    DDRAM_DOUT_READY = 1'b1;
    @(negedge DDRAM_CLK);
    reset = 1'b0;
    @(negedge DDRAM_CLK);
    DDRAM_DOUT_READY = 1'b0;
    repeat (4) @(negedge DDRAM_CLK);
    chk("late_rd_ack", rd_ack, 1'b0);
    chk("late_dout", dout, 16'h0);
    chk("late_no_rd", rd_hi - rd0, 0);

    // Request already high at reset release is serviced
    reset = 1'b1;
    rdaddr = {22'h7, 2'd3};
    rd_req = 1'b1;
    @(negedge DDRAM_CLK);
    reset = 1'b0;
    wait_for(1'b0, idx);
    chk("rel_rd_lat", idx, 3);
    if (idx != 0) rd_finish({22'h7, 2'd3}, 0, 2, 1'b0, w);

    chk("rd_we_overlap", both_hi, 0);
    chk("burstcnt_const", bad_burst, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
